stopwatch_lap: RTL and testbench

//  Parametrised stopwatch with run/pause/clear control, a lap-capture buffer and a

---
 rtl/stopwatch_lap.sv | 247 ++++++++++++++++++++++++
 tb/tb_stopwatch_lap.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_lap.sv
// BCD stopwatch (mm:ss:cc) with run/pause/clear, lap buffer and a 2x16 LCD text source.
// Optional hours digit when SW_HOURS_EN is defined.
module stopwatch_lap #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 100,
  parameter int LAP_DEPTH = 4,
  parameter int MAX_MIN   = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  input  logic [3:0] lap_sel,
  input  logic [4:0] index,
  output logic [7:0] out,
  output logic       running,
  output logic [3:0] lap_count,
  output logic       lap_full,
  output logic [1:0] state_dbg
);

  // Control pulses (start_stop, clear, lap) are single-cycle strobes sampled on
  // every rising clk edge; there is no ready/back-pressure, each pulse acts once.

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [3:0]    DEPTH4     = 4'(LAP_DEPTH);
  localparam logic [7:0]    DASH       = 8'h2d;
  localparam logic [7:0]    SPACE      = 8'h20;

`ifdef SW_HOURS_EN
  localparam int TW = 28;
  localparam logic [3:0] MIN_T = 4'd5;
  localparam logic [3:0] MIN_U = 4'd9;
`else
  localparam int TW = 24;
  localparam logic [3:0] MIN_T = 4'(MAX_MIN / 10);
  localparam logic [3:0] MIN_U = 4'(MAX_MIN % 10);
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [3:0]    mm_t, mm_u, ss_t, ss_u, cc_t, cc_u;
  logic [3:0]    nx_mm_t, nx_mm_u, nx_ss_t, nx_ss_u, nx_cc_t, nx_cc_u;
  logic          c_s, c_m;
  logic          tick;
  logic [TW-1:0] cur_time;
  logic [TW-1:0] sel_time;
  logic [TW-1:0] lap_mem [LAP_DEPTH];
  logic          lap_valid, sel_in_range;
  logic [7:0]    ch;

`ifdef SW_HOURS_EN
  logic [3:0] hh, nx_hh;
  logic       c_h;
  assign cur_time = {hh, mm_t, mm_u, ss_t, ss_u, cc_t, cc_u};
`else
  assign cur_time = {mm_t, mm_u, ss_t, ss_u, cc_t, cc_u};
`endif

  assign tick      = (state == S_RUN) && (presc == PRESC_LAST);
  assign state_dbg = state;

  // Ripple-carry BCD increment, evaluated every cycle, applied only on tick.
  always_comb begin
    nx_cc_u = cc_u;
    nx_cc_t = cc_t;
    nx_ss_u = ss_u;
    nx_ss_t = ss_t;
    nx_mm_u = mm_u;
    nx_mm_t = mm_t;
    c_s     = 1'b0;
    c_m     = 1'b0;
`ifdef SW_HOURS_EN
    nx_hh   = hh;
    c_h     = 1'b0;
`endif
    if (cc_u == 4'd9) begin
      nx_cc_u = 4'd0;
      if (cc_t == 4'd9) begin
        nx_cc_t = 4'd0;
        c_s     = 1'b1;
      end else begin
        nx_cc_t = cc_t + 4'd1;
      end
    end else begin
      nx_cc_u = cc_u + 4'd1;
    end
    if (c_s) begin
      if (ss_u == 4'd9) begin
        nx_ss_u = 4'd0;
        if (ss_t == 4'd5) begin
          nx_ss_t = 4'd0;
          c_m     = 1'b1;
        end else begin
          nx_ss_t = ss_t + 4'd1;
        end
      end else begin
        nx_ss_u = ss_u + 4'd1;
      end
    end
    if (c_m) begin
      if (mm_t == MIN_T && mm_u == MIN_U) begin
        nx_mm_t = 4'd0;
        nx_mm_u = 4'd0;
`ifdef SW_HOURS_EN
        c_h     = 1'b1;
`endif
      end else if (mm_u == 4'd9) begin
        nx_mm_u = 4'd0;
        nx_mm_t = mm_t + 4'd1;
      end else begin
        nx_mm_u = mm_u + 4'd1;
      end
    end
`ifdef SW_HOURS_EN
    if (c_h) nx_hh = (hh == 4'd9) ? 4'd0 : hh + 4'd1;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      running   <= 1'b0;
      presc     <= '0;
      {mm_t, mm_u, ss_t, ss_u, cc_t, cc_u} <= '0;
`ifdef SW_HOURS_EN
      hh        <= 4'd0;
`endif
      lap_count <= 4'd0;
      lap_full  <= 1'b0;
      for (int i = 0; i < LAP_DEPTH; i++) lap_mem[i] <= '0;
    end else if (clear) begin
      state     <= S_IDLE;
      running   <= 1'b0;
      presc     <= '0;
      {mm_t, mm_u, ss_t, ss_u, cc_t, cc_u} <= '0;
`ifdef SW_HOURS_EN
      hh        <= 4'd0;
`endif
      lap_count <= 4'd0;
      lap_full  <= 1'b0;
    end else begin
      if (start_stop) begin
        case (state)
          S_RUN: begin
            state   <= S_PAUSE;
            running <= 1'b0;
          end
          default: begin
            state   <= S_RUN;
            running <= 1'b1;
          end
        endcase
      end
      // The prescaler still advances on the cycle that pauses, so the partial
      // centisecond is carried across a pause.
      if (state == S_RUN) begin
        if (tick) begin
          presc <= '0;
          {mm_t, mm_u, ss_t, ss_u, cc_t, cc_u} <=
            {nx_mm_t, nx_mm_u, nx_ss_t, nx_ss_u, nx_cc_t, nx_cc_u};
`ifdef SW_HOURS_EN
          hh <= nx_hh;
`endif
        end else begin
          presc <= presc + 1'b1;
        end
        if (lap && !start_stop && !lap_full) begin
          for (int i = 0; i < LAP_DEPTH; i++)
            if (lap_count == 4'(i)) lap_mem[i] <= cur_time;
          lap_count <= lap_count + 4'd1;
          lap_full  <= ((lap_count + 4'd1) == DEPTH4);
        end
      end
    end
  end

  always_comb begin
    sel_time = '0;
    for (int i = 0; i < LAP_DEPTH; i++)
      if (lap_sel == 4'(i)) sel_time = lap_mem[i];
  end

  assign lap_valid    = (lap_sel < lap_count);
  assign sel_in_range = (lap_sel < DEPTH4);

  function automatic logic [7:0] dig(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  function automatic logic [7:0] lap_dig(input logic v, input logic [3:0] d);
    return v ? (8'h30 + {4'h0, d}) : DASH;
  endfunction

  always_comb begin
    ch = SPACE;
    case (index)
      5'd0:  ch = "L";
      5'd1:  ch = "A";
      5'd2:  ch = "P";
      5'd4:  ch = sel_in_range ? (8'h31 + {4'h0, lap_sel}) : DASH;
`ifdef SW_HOURS_EN
      5'd5:  ch = lap_dig(lap_valid, sel_time[27:24]);
`endif
      5'd6:  ch = lap_dig(lap_valid, sel_time[23:20]);
      5'd7:  ch = lap_dig(lap_valid, sel_time[19:16]);
      5'd8:  ch = ":";
      5'd9:  ch = lap_dig(lap_valid, sel_time[15:12]);
      5'd10: ch = lap_dig(lap_valid, sel_time[11:8]);
      5'd11: ch = ":";
      5'd12: ch = lap_dig(lap_valid, sel_time[7:4]);
      5'd13: ch = lap_dig(lap_valid, sel_time[3:0]);
      5'd16: ch = "T";
      5'd17: ch = "I";
      5'd18: ch = "M";
      5'd19: ch = "E";
`ifdef SW_HOURS_EN
      5'd20: ch = dig(hh);
`endif
      5'd21: ch = dig(mm_t);
      5'd22: ch = dig(mm_u);
      5'd23: ch = ":";
      5'd24: ch = dig(ss_t);
      5'd25: ch = dig(ss_u);
      5'd26: ch = ":";
      5'd27: ch = dig(cc_t);
      5'd28: ch = dig(cc_u);
      5'd30: ch = (state == S_RUN) ? "R" : (state == S_PAUSE) ? "P" : SPACE;
      default: ch = SPACE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) out <= 8'h00;
    else      out <= ch;
  end

endmodule

// File: tb/tb_stopwatch_lap.sv
// Directed bench for stopwatch_lap: a 10-clk-per-tick instance for control, laps and
// display, plus a one-tick-per-clk instance (MAX_MIN=1) for minute carry and wrap.
module tb_stopwatch_lap;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [3:0] lap_sel = 4'd0;
  logic [4:0] index = 5'd0;
  logic [7:0] out;
  logic       running, lap_full;
  logic [3:0] lap_count;
  logic [1:0] state_dbg;

  logic       start_stop_w = 1'b0, clear_w = 1'b0, lap_w = 1'b0;
  logic [3:0] lap_sel_w = 4'd0;
  logic [4:0] index_w = 5'd0;
  logic [7:0] out_w;
  logic       running_w, lap_full_w;
  logic [3:0] lap_count_w;
  logic [1:0] state_dbg_w;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stopwatch_lap #(.CLK_HZ(1000), .TICK_HZ(100), .LAP_DEPTH(4), .MAX_MIN(59)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap),
    .lap_sel(lap_sel), .index(index), .out(out), .running(running),
    .lap_count(lap_count), .lap_full(lap_full), .state_dbg(state_dbg)
  );

  stopwatch_lap #(.CLK_HZ(100), .TICK_HZ(100), .LAP_DEPTH(4), .MAX_MIN(1)) dut_w (
    .clk(clk), .rst(rst), .start_stop(start_stop_w), .clear(clear_w), .lap(lap_w),
    .lap_sel(lap_sel_w), .index(index_w), .out(out_w), .running(running_w),
    .lap_count(lap_count_w), .lap_full(lap_full_w), .state_dbg(state_dbg_w)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
    end
  endtask

  // Drive index at a falling edge; the registered character is read one edge later.
  task automatic chk_ch(input string tag, input logic [4:0] idx, input logic [7:0] exp);
    index = idx;
    @(negedge clk);
    check_eq(tag, out, exp);
  endtask

  task automatic chk_ch_w(input string tag, input logic [4:0] idx, input logic [7:0] exp);
    index_w = idx;
    @(negedge clk);
    check_eq(tag, out_w, exp);
  endtask

  task automatic pulse_start();
    start_stop = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
  endtask

  task automatic pulse_start_w();
    start_stop_w = 1'b1;
    @(negedge clk);
    start_stop_w = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_out", out, 8'h00);
    check_eq("rst_running", {7'd0, running}, 8'd0);
    check_eq("rst_lap_count", {4'd0, lap_count}, 8'd0);
    check_eq("rst_lap_full", {7'd0, lap_full}, 8'd0);
    rst = 1'b1;
    @(negedge clk);
    chk_ch("idx16", 5'd16, "T");
    chk_ch("idx17", 5'd17, "I");
    chk_ch("idx18", 5'd18, "M");
    chk_ch("idx19", 5'd19, "E");
    chk_ch("idx30_idle", 5'd30, " ");
    chk_ch("idx20_blank", 5'd20, " ");
    check_eq("idle_running", {7'd0, running}, 8'd0);

    // Run for 1000 clk = 100 ticks -> 00:01:00
    pulse_start();
    repeat (1000) @(negedge clk);
    chk_ch("run1s_s_t", 5'd24, "0");
    chk_ch("run1s_s_u", 5'd25, "1");
    chk_ch("run1s_c_t", 5'd27, "0");
    chk_ch("run1s_c_u", 5'd28, "0");
    check_eq("run_running", {7'd0, running}, 8'd1);
    check_eq("run_state", {6'd0, state_dbg}, 8'd1);

    // Clear returns to IDLE; lap in IDLE is ignored
    pulse_clear();
    check_eq("clr_running", {7'd0, running}, 8'd0);
    chk_ch("clr_s_u", 5'd25, "0");
    chk_ch("clr_c_u", 5'd28, "0");
    pulse_lap();
    check_eq("lap_idle_ign", {4'd0, lap_count}, 8'd0);

    // Pause at 00:00:37 with half a centisecond elapsed, resume finishes it
    pulse_start();
    repeat (374) @(negedge clk);
    pulse_start();
    repeat (200) @(negedge clk);
    chk_ch("pause_st", 5'd30, "P");
    chk_ch("pause_c_t", 5'd27, "3");
    chk_ch("pause_c_u", 5'd28, "7");
    pulse_lap();
    check_eq("lap_pause_ign", {4'd0, lap_count}, 8'd0);
    pulse_start();
    chk_ch("resume_st", 5'd30, "R");
    chk_ch("resume_c_u0", 5'd28, "7");
    repeat (2) @(negedge clk);
    chk_ch("resume_c_u4", 5'd28, "7");
    chk_ch("resume_c_u5", 5'd28, "8");

    // Laps at 00:00:05, :12, :19 (tick cycle), :33, then one more while full
    pulse_clear();
    pulse_start();
    repeat (54) @(negedge clk);
    pulse_lap();
    check_eq("lap_cnt1", {4'd0, lap_count}, 8'd1);
    lap_sel = 4'd1;
    chk_ch("sel1_pos4", 5'd4, "2");
    chk_ch("sel1_empty", 5'd6, "-");
    lap_sel = 4'd0;
    chk_ch("slot0_c_u", 5'd13, "5");
    chk_ch("slot0_c_t", 5'd12, "0");
    repeat (65) @(negedge clk);
    pulse_lap();
    check_eq("lap_cnt2", {4'd0, lap_count}, 8'd2);
    repeat (74) @(negedge clk);
    pulse_lap();
    check_eq("lap_cnt3", {4'd0, lap_count}, 8'd3);
    check_eq("lap_full3", {7'd0, lap_full}, 8'd0);
    repeat (132) @(negedge clk);
    pulse_lap();
    check_eq("lap_cnt4", {4'd0, lap_count}, 8'd4);
    check_eq("lap_full4", {7'd0, lap_full}, 8'd1);
    repeat (76) @(negedge clk);
    pulse_lap();
    check_eq("lap_cnt_sat", {4'd0, lap_count}, 8'd4);
    lap_sel = 4'd3;
    chk_ch("slot3_pos4", 5'd4, "4");
    chk_ch("slot3_s_u", 5'd10, "0");
    chk_ch("slot3_c_t", 5'd12, "3");
    chk_ch("slot3_c_u", 5'd13, "3");
    lap_sel = 4'd2;
    chk_ch("slot2_c_t", 5'd12, "1");
    chk_ch("slot2_c_u", 5'd13, "9");
    lap_sel = 4'd1;
    chk_ch("slot1_c_u", 5'd13, "2");
    lap_sel = 4'd5;
    chk_ch("sel5_pos4", 5'd4, "-");
    chk_ch("sel5_m_t", 5'd6, "-");
    chk_ch("sel5_c_u", 5'd13, "-");
    lap_sel = 4'd4;
    chk_ch("sel4_pos4", 5'd4, "-");
    chk_ch("line1_L", 5'd0, "L");
    chk_ch("line1_colon", 5'd8, ":");
    pulse_clear();
    check_eq("clr_lap_count", {4'd0, lap_count}, 8'd0);
    check_eq("clr_lap_full", {7'd0, lap_full}, 8'd0);
    check_eq("clr_state", {6'd0, state_dbg}, 8'd0);
    chk_ch("clr2_c_u", 5'd28, "0");

    // clear and start_stop together while running: clear wins
    pulse_start();
    repeat (50) @(negedge clk);
    clear = 1'b1;
    start_stop = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    start_stop = 1'b0;
    check_eq("clrss_running", {7'd0, running}, 8'd0);
    repeat (30) @(negedge clk);
    chk_ch("clrss_st", 5'd30, " ");
    chk_ch("clrss_c_t", 5'd27, "0");
    chk_ch("clrss_c_u", 5'd28, "0");

    // One tick per clk: 00:59:99 -> 01:00:00, then 01:59:99 -> 00:00:00 (MAX_MIN=1)
    pulse_start_w();
    repeat (5999) @(negedge clk);
    index_w = 5'd25;
    start_stop_w = 1'b1;
    @(negedge clk);
    start_stop_w = 1'b0;
    check_eq("w_pre_s_u", out_w, "9");
    chk_ch_w("w_m_u", 5'd22, "1");
    chk_ch_w("w_s_t", 5'd24, "0");
    chk_ch_w("w_s_u", 5'd25, "0");
    chk_ch_w("w_c_u", 5'd28, "0");
    pulse_start_w();
    repeat (5999) @(negedge clk);
    index_w = 5'd22;
    start_stop_w = 1'b1;
    @(negedge clk);
    start_stop_w = 1'b0;
    check_eq("w_prewrap_m_u", out_w, "1");
    chk_ch_w("wrap_m_u", 5'd22, "0");
    chk_ch_w("wrap_s_u", 5'd25, "0");
    chk_ch_w("wrap_c_u", 5'd28, "0");
    chk_ch_w("wrap_st", 5'd30, "P");
    check_eq("wrap_state", {6'd0, state_dbg_w}, 8'd2);
    check_eq("wrap_running", {7'd0, running_w}, 8'd0);
    check_eq("w_lap_count", {4'd0, lap_count_w}, 8'd0);
    check_eq("w_lap_full", {7'd0, lap_full_w}, 8'd0);

    // Asynchronous reset mid-run with laps stored
    pulse_start();
    repeat (20) @(negedge clk);
    pulse_lap();
    index = 5'd16;
    repeat (20) @(negedge clk);
    check_eq("pre_arst_count", {4'd0, lap_count}, 8'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_out", out, 8'h00);
    check_eq("arst_running", {7'd0, running}, 8'd0);
    check_eq("arst_lap_count", {4'd0, lap_count}, 8'd0);
    check_eq("arst_lap_full", {7'd0, lap_full}, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_ch("post_arst_st", 5'd30, " ");
    repeat (30) @(negedge clk);
    chk_ch("post_arst_c_u", 5'd28, "0");
    chk_ch("post_arst_c_t", 5'd27, "0");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
